// File: rtl/weight_rotator.sv
// weight_rotator: loads a block of weight words into an external RAM, then
// streams that block back a configurable number of times over a valid/ready
// output. Tags for valid and last travel alongside the RAM read pipeline.
`ifndef K_BITS
`define K_BITS 8
`endif
`ifndef RAM_WEIGHTS_DEPTH
`define RAM_WEIGHTS_DEPTH 16
`endif
`ifndef DELAY_W_RAM
`define DELAY_W_RAM 2
`endif

module weight_rotator #(
  parameter int unsigned WIDTH      = `K_BITS,
  parameter int unsigned DEPTH      = `RAM_WEIGHTS_DEPTH,
  parameter int unsigned LATENCY    = `DELAY_W_RAM,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic [CNT_W-1:0]      cfg_reps,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  done,
  output logic                  err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_di,
  input  logic [WIDTH-1:0]      ram_dout
);

  typedef enum logic [1:0] {IDLE, FILL, READ, DRAIN} state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   len_q, reps_q, wcnt_q, eff_len_q, raddr_q, pass_q;
  logic [LATENCY-1:0] vld_q, last_q;

  logic adv, pipe_empty, fill_at_len, fill_end, read_last_addr, final_issue, issue;

  assign m_valid        = vld_q[LATENCY-1];
  assign m_last         = last_q[LATENCY-1];
  assign m_data         = ram_dout;
  assign adv            = ~m_valid | m_ready;
  assign pipe_empty     = (vld_q == '0);
  assign fill_at_len    = (wcnt_q == len_q - CNT_W'(1));
  assign fill_end       = s_valid & (fill_at_len | s_last);
  assign read_last_addr = (raddr_q == eff_len_q - CNT_W'(1));
  assign final_issue    = read_last_addr & (pass_q == reps_q - CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state and RAM/handshake control
  always_comb begin
    state_n   = state_q;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_di    = '0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_len != '0) state_n = FILL;
      end
      FILL: begin
        s_ready  = 1'b1;
        ram_en   = 1'b1;
        ram_we   = s_valid;
        ram_addr = ADDR_WIDTH'(wcnt_q);
        ram_di   = s_data;
        if (fill_end) state_n = (reps_q == '0) ? DRAIN : READ;
      end
      READ: begin
        ram_en   = adv;
        ram_addr = ADDR_WIDTH'(raddr_q);
        issue    = adv;
        if (adv && final_issue) state_n = DRAIN;
      end
      DRAIN: begin
        // keep the RAM pipeline moving so in-flight words reach the output
        ram_en   = adv;
        ram_addr = ADDR_WIDTH'(raddr_q);
        if (pipe_empty) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Job counters, status flags and the valid/last tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      reps_q    <= '0;
      wcnt_q    <= '0;
      eff_len_q <= '0;
      raddr_q   <= '0;
      pass_q    <= '0;
      vld_q     <= '0;
      last_q    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            len_q  <= (cfg_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_len;
            reps_q <= cfg_reps;
            wcnt_q <= '0;
            if (cfg_len > CNT_W'(DEPTH)) err  <= 1'b1;
            if (cfg_len == '0)           done <= 1'b1;
          end
        end
        FILL: begin
          if (s_valid) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
            // s_last must coincide exactly with the final expected beat
            if (s_last != fill_at_len) err <= 1'b1;
            if (fill_end) begin
              eff_len_q <= wcnt_q + CNT_W'(1);
              raddr_q   <= '0;
              pass_q    <= '0;
            end
          end
        end
        READ: begin
          if (issue) begin
            if (read_last_addr) begin
              raddr_q <= '0;
              pass_q  <= pass_q + CNT_W'(1);
            end else begin
              raddr_q <= raddr_q + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) done <= 1'b1;
        end
        default: ;
      endcase
      if (adv && (state_q == READ || state_q == DRAIN)) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          vld_q[i]  <= vld_q[i-1];
          last_q[i] <= last_q[i-1];
        end
        vld_q[0]  <= issue;
        last_q[0] <= issue & read_last_addr;
      end
    end
  end

endmodule

// File: tb/tb_weight_rotator.sv
// Bench for weight_rotator: RAM model, per-job stimulus table plus random jobs.
module tb_weight_rotator;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cfg_len, cfg_reps;
  logic             cfg_valid, cfg_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_valid, s_ready, s_last;
  logic [WIDTH-1:0] m_data;
  logic             m_valid, m_ready, m_last;
  logic             done, err;
  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_di, ram_dout;

  weight_rotator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY),
                   .ADDR_WIDTH(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_len(cfg_len), .cfg_reps(cfg_reps), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .done(done), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM with LATENCY-cycle read pipeline advancing only when enabled
  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] rpipe [LATENCY];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      rpipe[0] <= mem[ram_addr];
      for (int i = 1; i < LATENCY; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign ram_dout = rpipe[LATENCY-1];

  int total = 0, bad = 0;
  int wr_cnt = 0, en_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && ram_en) begin
      en_cnt++;
      if (ram_we) wr_cnt++;
    end
  end

  // Reference: word k of a job is ref_mem[k mod L], last when k mod L == L-1
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int exp_L = 0, exp_total = 0, exp_k = 0;
  int first_cyc = -1, last_cyc = 0, cyc = 0;
  logic             stalled = 1'b0, hold_l;
  logic [WIDTH-1:0] hold_d;

  // Output monitor: compares accepted words and checks stall stability
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, hold_d);
        check("stall_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        check("word_expected", exp_k < exp_total, 1);
        if (exp_k < exp_total) begin
          check($sformatf("m_data_w%0d", exp_k), m_data, ref_mem[exp_k % exp_L]);
          check($sformatf("m_last_w%0d", exp_k), m_last, (exp_k % exp_L) == exp_L - 1);
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
        exp_k++;
      end
      stalled = m_valid && !m_ready;
      hold_d  = m_data;
      hold_l  = m_last;
    end
  end

  // m_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  int rmode_g = 0;
  initial begin
    int rcyc = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rcyc++;
      case (rmode_g)
        0:       m_ready = 1'b1;
        1:       m_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  typedef struct {
    int len; int reps; int last_at; int rmode;
    bit rst_before; int abort_after; int exp_L; bit exp_err;
  } job_t;

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_job(input job_t j, input int idx);
    logic [WIDTH-1:0] d [DEPTH];
    int wr0, en0, waited;
    bit seen;
    if (j.rst_before) do_reset();
    for (int i = 0; i < j.exp_L; i++) begin
      d[i] = WIDTH'($urandom);
      ref_mem[i] = d[i];
    end
    exp_L = j.exp_L; exp_total = j.exp_L * j.reps; exp_k = 0; first_cyc = -1;
    rmode_g = j.rmode;
    wr0 = wr_cnt; en0 = en_cnt;
    @(posedge clk); #1;
    check($sformatf("j%0d_cfg_ready", idx), cfg_ready, 1);
    cfg_valid = 1'b1; cfg_len = CNT_W'(j.len); cfg_reps = CNT_W'(j.reps);
    @(posedge clk); #1;
    if (j.len == 0) begin
      cfg_valid = 1'b0;
      @(negedge clk);
      check($sformatf("j%0d_len0_done", idx), done, 1);
      check($sformatf("j%0d_len0_err", idx), err, j.exp_err);
      @(negedge clk);
      check($sformatf("j%0d_len0_done_off", idx), done, 0);
      check($sformatf("j%0d_len0_ram_en", idx), en_cnt - en0, 0);
      return;
    end
    cfg_len = CNT_W'(7);  // still offered while busy; must be ignored
    for (int b = 0; b < j.exp_L; b++) begin
      if (j.rmode == 2 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0; @(posedge clk); #1;
      end
      if (b == 0) begin
        check($sformatf("j%0d_s_ready", idx), s_ready, 1);
        check($sformatf("j%0d_cfg_busy", idx), cfg_ready, 0);
      end
      s_valid = 1'b1; s_data = d[b]; s_last = (b == j.last_at);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0; cfg_valid = 1'b0;
    waited = 0; seen = 1'b0;
    while (!seen && waited < 4000) begin
      @(negedge clk);
      waited++;
      if (j.abort_after > 0 && exp_k >= j.abort_after) begin
        do_reset();
        @(negedge clk);
        check($sformatf("j%0d_abort_m_valid", idx), m_valid, 0);
        check($sformatf("j%0d_abort_cfg_ready", idx), cfg_ready, 1);
        check($sformatf("j%0d_abort_ram_en", idx), ram_en, 0);
        check($sformatf("j%0d_abort_err", idx), err, 0);
        exp_total = 0; exp_k = 0;
        return;
      end
      if (done) seen = 1'b1;
    end
    check($sformatf("j%0d_done_seen", idx), seen, 1);
    check($sformatf("j%0d_words", idx), exp_k, exp_total);
    check($sformatf("j%0d_err", idx), err, j.exp_err);
    check($sformatf("j%0d_writes", idx), wr_cnt - wr0, j.exp_L);
    if (j.rmode == 0 && exp_total > 0)
      check($sformatf("j%0d_no_bubbles", idx), last_cyc - first_cyc, exp_total - 1);
    @(negedge clk);
    check($sformatf("j%0d_done_pulse", idx), done, 0);
  endtask

  job_t jobs [13];

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_reps = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);

    //          len        reps   last rm rst abort L  err
    jobs[0]  = '{4,         3,     3,  0, 0,  0,    4, 0};
    jobs[1]  = '{4,         3,     3,  1, 0,  0,    4, 0};
    jobs[2]  = '{4,         2,     1,  0, 0,  0,    2, 1};
    jobs[3]  = '{4,         1,     3,  2, 0,  0,    4, 1};
    jobs[4]  = '{DEPTH + 5, 1,    -1,  2, 1,  0,    DEPTH, 1};
    jobs[5]  = '{0,         5,    -1,  0, 1,  0,    0, 0};
    jobs[6]  = '{3,         0,     2,  0, 1,  0,    3, 0};
    jobs[7]  = '{1,         4,     0,  2, 0,  0,    1, 0};
    jobs[8]  = '{DEPTH,     2,     DEPTH - 1, 1, 0, 0, DEPTH, 0};
    jobs[9]  = '{5,         2,    -1,  0, 0,  0,    5, 1};
    jobs[10] = '{4,         3,     3,  2, 1,  6,    4, 0};
    jobs[11] = '{4,         1,     3,  0, 0,  0,    4, 0};
    jobs[12] = '{2,         65535, 1,  0, 0,  40,   2, 0};
    for (int i = 0; i < 13; i++) run_job(jobs[i], i);

    // Random jobs; expected length and error derived from the loading rules
    for (int i = 0; i < 8; i++) begin
      job_t j;
      int len_e;
      j.len = int'($urandom_range(1, DEPTH + 2));
      j.reps = int'($urandom_range(0, 3));
      j.last_at = int'($urandom_range(0, j.len)) - 1;
      j.rmode = 2; j.rst_before = 1'b1; j.abort_after = 0;
      len_e = (j.len > DEPTH) ? DEPTH : j.len;
      j.exp_L = (j.last_at >= 0 && j.last_at < len_e) ? j.last_at + 1 : len_e;
      j.exp_err = (j.len > DEPTH) || (j.last_at != len_e - 1);
      run_job(j, 100 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
